// File: rtl/fetch_ctrl_if.sv
// Fetch control bundle: redirect/trap/stall/debug requests in, fetch-stage controls out.
// Optional perf counters (FETCH_CTRL_PERF_EN) are plain ports on fetch_ctrl, not part of this bundle.
interface fetch_ctrl_if;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        backend_stall;
   logic        halt_req;
   logic        resume;
   logic [31:0] nextpc;
   logic        fetch_stall;
   logic        fetch_kill;
   logic        inst_valid;
   logic        halted;
   logic [31:0] cur_pc;

   modport master (
      output trap_valid, trap_pc, redirect_valid, redirect_pc,
             backend_stall, halt_req, resume,
      input  nextpc, fetch_stall, fetch_kill, inst_valid, halted, cur_pc
   );

   modport slave (
      input  trap_valid, trap_pc, redirect_valid, redirect_pc,
             backend_stall, halt_req, resume,
      output nextpc, fetch_stall, fetch_kill, inst_valid, halted, cur_pc
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Next-PC sequencer for the fetch stage: trap > redirect > stall > PC+INST_BYTES.
// Define FETCH_CTRL_PERF_EN to add saturating redirect_count / bubble_count outputs.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          INST_BYTES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   fetch_ctrl_if.slave fif
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0] redirect_count,
   output logic [31:0] bubble_count
`endif
);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

   state_t      state, nstate;
   logic [31:0] pc_q;
   logic [31:0] npc;
   logic        accept;
   logic        stall;

   assign accept = fif.trap_valid | fif.redirect_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= BOOT;
         pc_q  <= RESET_PC;
      end else begin
         state <= nstate;
         if (!stall) pc_q <= npc;
      end
   end

   always_comb begin
      nstate = state;
      stall  = 1'b0;
      npc    = pc_q + 32'(INST_BYTES);
      case (state)
         BOOT:  nstate = RUN;
         RUN:   if (fif.halt_req) nstate = HALT;
                else if (accept)  nstate = FLUSH;
         FLUSH: if (fif.halt_req) nstate = HALT;
                else if (accept)  nstate = FLUSH;
                else              nstate = RUN;
         HALT:  if (fif.resume && !fif.halt_req) nstate = FLUSH;
         default: nstate = BOOT;
      endcase
      // an accepted redirect always lands, even in HALT or under back-pressure
      stall = !accept && (fif.backend_stall || state == HALT || nstate == HALT);
      if (fif.trap_valid)          npc = fif.trap_pc;
      else if (fif.redirect_valid) npc = fif.redirect_pc;
      else if (stall)              npc = pc_q;
   end

   assign fif.nextpc      = npc;
   assign fif.fetch_stall = stall;
   assign fif.fetch_kill  = accept;
   assign fif.inst_valid  = (state == RUN);
   assign fif.halted      = (state == HALT);
   assign fif.cur_pc      = pc_q;

`ifdef FETCH_CTRL_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         redirect_count <= '0;
         bubble_count   <= '0;
      end else begin
         if (accept && redirect_count != 32'hFFFF_FFFF)
            redirect_count <= redirect_count + 32'd1;
         if (state != RUN && state != HALT && bubble_count != 32'hFFFF_FFFF)
            bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes per-cycle expectations, monitor checks at negedge.
module tb_fetch_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fetch_ctrl_if fif ();

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] redirect_count, bubble_count;
   fetch_ctrl dut (.clk(clk), .reset_n(reset_n), .fif(fif),
                   .redirect_count(redirect_count), .bubble_count(bubble_count));
`else
   fetch_ctrl dut (.clk(clk), .reset_n(reset_n), .fif(fif));
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] np;
      logic        iv, h, st, k;
      logic        chkp;
      logic [31:0] rc, bc;
      logic [7:0]  id;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic        pend_chk = 1'b0;
   logic [31:0] pend_rc = '0, pend_bc = '0;
   logic [7:0]  cyc_id = '0;

   task automatic perf(input logic [31:0] rc, input logic [31:0] bc);
      pend_chk = 1'b1; pend_rc = rc; pend_bc = bc;
   endtask

   task automatic cyc(input logic rst, input logic arst,
                      input logic tv, input logic [31:0] tpc,
                      input logic rv, input logic [31:0] rpc,
                      input logic bs, input logic hr, input logic rs,
                      input logic [31:0] epc, input logic [31:0] enp,
                      input logic eiv, input logic eh, input logic est, input logic ek);
      exp_t e;
      @(posedge clk); #1;
      fif.trap_valid = tv; fif.trap_pc = tpc;
      fif.redirect_valid = rv; fif.redirect_pc = rpc;
      fif.backend_stall = bs; fif.halt_req = hr; fif.resume = rs;
      if (arst) begin #1 reset_n = 1'b0; end
      else reset_n = rst;
      e.pc = epc; e.np = enp; e.iv = eiv; e.h = eh; e.st = est; e.k = ek;
      e.chkp = pend_chk; e.rc = pend_rc; e.bc = pend_bc; e.id = cyc_id;
      q.push_back(e);
      pend_chk = 1'b0;
      cyc_id++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         n_cmp++;
         if ({fif.cur_pc, fif.nextpc, fif.inst_valid, fif.halted, fif.fetch_stall, fif.fetch_kill}
             !== {e.pc, e.np, e.iv, e.h, e.st, e.k}) begin
            n_bad++;
            $display("FAIL cyc%0d outputs: got pc=%h np=%h iv=%b h=%b st=%b k=%b want pc=%h np=%h iv=%b h=%b st=%b k=%b",
                     e.id, fif.cur_pc, fif.nextpc, fif.inst_valid, fif.halted, fif.fetch_stall,
                     fif.fetch_kill, e.pc, e.np, e.iv, e.h, e.st, e.k);
         end
`ifdef FETCH_CTRL_PERF_EN
         if (e.chkp) begin
            n_cmp++;
            if ({redirect_count, bubble_count} !== {e.rc, e.bc}) begin
               n_bad++;
               $display("FAIL cyc%0d perf: got rc=%0d bc=%0d want rc=%0d bc=%0d",
                        e.id, redirect_count, bubble_count, e.rc, e.bc);
            end
         end
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      fif.trap_valid = 0; fif.trap_pc = '0; fif.redirect_valid = 0; fif.redirect_pc = '0;
      fif.backend_stall = 0; fif.halt_req = 0; fif.resume = 0;
      //  rst arst tv tpc     rv rpc      bs hr rs   pc       np       iv h st k
      cyc(0, 0,  0, 0,      0, 0,       0, 0, 0,   'h0,     'h4,     0, 0, 0, 0); // C0 in reset
      perf(0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h0,     'h4,     0, 0, 0, 0); // C1 BOOT
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h4,     'h8,     1, 0, 0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h8,     'hc,     1, 0, 0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'hc,     'h10,    1, 0, 0, 0);
      // backend stall for 3 cycles at 0x10
      cyc(1, 0,  0, 0,      0, 0,       1, 0, 0,   'h10,    'h10,    1, 0, 1, 0);
      cyc(1, 0,  0, 0,      0, 0,       1, 0, 0,   'h10,    'h10,    1, 0, 1, 0);
      cyc(1, 0,  0, 0,      0, 0,       1, 0, 0,   'h10,    'h10,    1, 0, 1, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h10,    'h14,    1, 0, 0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h14,    'h18,    1, 0, 0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h18,    'h1c,    1, 0, 0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h1c,    'h20,    1, 0, 0, 0);
      // redirect under backend stall
      cyc(1, 0,  0, 0,      1, 'h200,   1, 0, 0,   'h20,    'h200,   1, 0, 0, 1);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h200,   'h204,   0, 0, 0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h204,   'h208,   1, 0, 0, 0);
      // trap and redirect together: trap wins
      cyc(1, 0,  1, 'h80,   1, 'h300,   0, 0, 0,   'h208,   'h80,    1, 0, 0, 1);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h80,    'h84,    0, 0, 0, 0);
      perf(2, 3);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h84,    'h88,    1, 0, 0, 0);
      cyc(1, 0,  0, 0,      1, 'h40,    0, 0, 0,   'h88,    'h40,    1, 0, 0, 1);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h40,    'h44,    0, 0, 0, 0);
      // halt, redirect while halted, resume blocked by halt_req, then resume
      cyc(1, 0,  0, 0,      0, 0,       0, 1, 0,   'h44,    'h44,    1, 0, 1, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 1, 0,   'h44,    'h44,    0, 1, 1, 0);
      cyc(1, 0,  0, 0,      1, 'h500,   0, 1, 0,   'h44,    'h500,   0, 1, 0, 1);
      cyc(1, 0,  0, 0,      0, 0,       0, 1, 1,   'h500,   'h500,   0, 1, 1, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h500,   'h500,   0, 1, 1, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 1,   'h500,   'h500,   0, 1, 1, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h500,   'h504,   0, 0, 0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h504,   'h508,   1, 0, 0, 0);
      perf(4, 5);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h508,   'h50c,   1, 0, 0, 0);
      // resume outside HALT is ignored
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 1,   'h50c,   'h510,   1, 0, 0, 0);
      cyc(1, 0,  0, 0,      1, 'h600,   0, 0, 0,   'h510,   'h600,   1, 0, 0, 1);
      // redirect in FLUSH keeps FLUSH; reset then lands asynchronously mid-FLUSH
      cyc(1, 0,  0, 0,      1, 'h700,   0, 0, 0,   'h600,   'h700,   0, 0, 0, 1);
      perf(0, 0);
      cyc(1, 1,  0, 0,      0, 0,       0, 0, 0,   'h0,     'h4,     0, 0, 0, 0);
      cyc(0, 0,  0, 0,      0, 0,       0, 0, 0,   'h0,     'h4,     0, 0, 0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h0,     'h4,     0, 0, 0, 0);
      cyc(1, 0,  0, 0,      0, 0,       0, 0, 0,   'h4,     'h8,     1, 0, 0, 0);
      @(negedge clk); #1;
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
